// File: rtl/pixel_write_buffer_sram.sv
// pixel_write_buffer_sram
// Write side of the 320x240 8-bit pixel plane SRAM. CPU writes (x, y, colour)
// are range-checked, converted to linear addresses and queued in a FIFO. The
// queue drains as 3-cycle SETUP/WRITE/HOLD transactions, started only when the
// pixel read engine leaves the bus free.
module pixel_write_buffer_sram #(
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clkPixel,
    input  logic          reset_n,
    input  logic [11:0]   h_count,
    input  logic [11:0]   v_count,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [8:0]    wr_x,
    input  logic [7:0]    wr_y,
    input  logic [7:0]    wr_data,
    input  logic          err_clr,
    output logic          range_err,
    output logic [CW-1:0] fifo_count,
    output logic          sram_grant,
    output logic          sram_we,
    output logic [16:0]   sram_addr,
    output logic [7:0]    sram_wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] ZERO_CNT = CW'(0);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Each FIFO entry is {address[16:0], colour[7:0]}.
    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          range_err_q, range_err_d;
    logic          grant_q, we_q;
    logic [16:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;

    logic          in_range_s, accept_s, push_s, bad_s, pop_s;
    logic          line_free_s, start_ok_s;
    logic [16:0]   lin_addr_s;
    logic [24:0]   head_s;
    logic [AW-1:0] head_idx_s;

    assign wr_ready   = (count_q != FULL_CNT);
    assign fifo_count = count_q;
    assign range_err  = range_err_q;
    assign sram_grant = grant_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // Accept path: range check and y*320 + x as two shifts plus an add.
    always_comb begin
        in_range_s  = (wr_x < 9'd320) && (wr_y < 8'd240);
        accept_s    = wr_valid && wr_ready;
        push_s      = accept_s && in_range_s;
        bad_s       = accept_s && !in_range_s;
        lin_addr_s  = ({9'd0, wr_y} << 8) + ({9'd0, wr_y} << 6) + {8'd0, wr_x};
        pop_s       = (state_q == S_HOLD);
        // Even v_count lines are served from the read engine's line buffer.
        line_free_s = (v_count < 12'd45) || (v_count[0] == 1'b0);
        // Starting by h=156 lets the 3-cycle transaction end before h=160.
        start_ok_s  = line_free_s || (h_count <= 12'd156);
    end

    // FIFO bookkeeping: pointers, occupancy and sticky range error.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
        if (push_s && !pop_s) begin
            count_d = count_q + ONE_CNT;
        end else if (!push_s && pop_s) begin
            count_d = count_q - ONE_CNT;
        end else begin
            count_d = count_q;
        end
        // A bad write in the same cycle as err_clr keeps the flag set.
        if (bad_s) begin
            range_err_d = 1'b1;
        end else if (err_clr) begin
            range_err_d = 1'b0;
        end else begin
            range_err_d = range_err_q;
        end
    end

    // Head of queue as seen after this cycle's pop; an entry pushed while the
    // only stored entry is being popped is forwarded straight from the input.
    always_comb begin
        head_idx_s = (state_q == S_HOLD) ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
        if ((state_q == S_HOLD) && (count_q == ONE_CNT)) begin
            head_s = {lin_addr_s, wr_data};
        end else begin
            head_s = mem_q[head_idx_s];
        end
    end

    // Transaction sequencer: SETUP -> WRITE -> HOLD, chaining back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != ZERO_CNT) && start_ok_s) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: state_d = S_WRITE;
            S_WRITE: state_d = S_HOLD;
            S_HOLD: begin
                if ((count_d != ZERO_CNT) && start_ok_s) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_SETUP) begin
            addr_d  = head_s[24:8];
            wdata_d = head_s[7:0];
        end else begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clkPixel) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {lin_addr_s, wr_data};
        end
    end

    // State, FIFO control and registered SRAM outputs.
    always_ff @(posedge clkPixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            range_err_q <= 1'b0;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 17'd0;
            wdata_q     <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            range_err_q <= range_err_d;
            grant_q     <= (state_d != S_IDLE);
            we_q        <= (state_d == S_WRITE);
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer_sram.sv
// Scoreboard bench for pixel_write_buffer_sram: accepted in-range writes push
// their expected {address, colour} into a queue; a monitor pops and compares on
// every sram_we cycle and checks the bus exclusion window on every grant cycle.
module tb_pixel_write_buffer_sram;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] h_count, v_count;
    logic        wr_valid, wr_ready, err_clr, range_err;
    logic [8:0]  wr_x;
    logic [7:0]  wr_y, wr_data;
    logic [4:0]  fifo_count;
    logic        sram_grant, sram_we;
    logic [16:0] sram_addr;
    logic [7:0]  sram_wdata;

    int checks   = 0;
    int failures = 0;

    logic [24:0] expq [$];
    logic [23:0] setup_q [$];
    int          we_cyc [$];

    pixel_write_buffer_sram #(.FIFO_DEPTH(16), .CW(5)) dut (
        .clkPixel  (clk),
        .reset_n   (reset_n),
        .h_count   (h_count),
        .v_count   (v_count),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_data   (wr_data),
        .err_clr   (err_clr),
        .range_err (range_err),
        .fifo_count(fifo_count),
        .sram_grant(sram_grant),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one cycle; timing counters change on the falling edge.
    task automatic cyc();
        @(negedge clk);
        if (h_count == 12'd799) begin
            h_count = 12'd0;
            v_count = (v_count == 12'd524) ? 12'd0 : v_count + 12'd1;
        end else begin
            h_count = h_count + 12'd1;
        end
    endtask

    task automatic do_push(input int x, input int y, input logic [7:0] d, input logic exp_ready);
        logic [16:0] a;
        wr_valid = 1'b1;
        wr_x     = x[8:0];
        wr_y     = y[7:0];
        wr_data  = d;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
        if (exp_ready && x < 320 && y < 240) begin
            a = 17'(y * 320 + x);
            expq.push_back({a, d});
        end
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((expq.size() != 0 || fifo_count != 5'd0 || sram_grant) && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_within_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    // Monitor: scoreboard compare on writes, exclusion check on grants.
    initial begin
        int          cyc_n = 0;
        logic        prev_we = 1'b0;
        logic [24:0] e;
        forever begin
            @(negedge clk);
            #1;
            cyc_n++;
            if (sram_grant && !sram_we && !prev_we) setup_q.push_back({v_count, h_count});
            if (sram_grant) begin
                checks++;
                if (v_count >= 12'd45 && v_count[0] && h_count >= 12'd160) begin
                    failures++;
                    $display("FAIL bus_exclusion actual=grant@v%0d,h%0d expected=no grant", v_count, h_count);
                end
            end
            if (sram_we) begin
                we_cyc.push_back(cyc_n);
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual=addr %0d data %0h expected=none", sram_addr, sram_wdata);
                end else begin
                    e = expq.pop_front();
                    if ({sram_addr, sram_wdata} !== e) begin
                        failures++;
                        $display("FAIL write_data actual=addr %0d data %0h expected=addr %0d data %0h",
                                 sram_addr, sram_wdata, e[24:8], e[7:0]);
                    end
                end
            end
            prev_we = sram_we;
        end
    end

    initial begin
        int st, wst;
        reset_n = 1'b0; wr_valid = 1'b0; err_clr = 1'b0;
        wr_x = 9'd0; wr_y = 8'd0; wr_data = 8'd0;
        h_count = 12'd0; v_count = 12'd10;
        repeat (3) cyc();
        chk("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        chk("rst_grant_we", {30'd0, sram_grant, sram_we}, 32'd0);
        chk("rst_addr_data", {7'd0, sram_addr, sram_wdata}, 32'd0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Single write with exact latency.
        do_push(5, 2, 8'hA5, 1'b1);
        chk("sw_p1_grant", {31'd0, sram_grant}, 32'd0);
        cyc();
        chk("sw_setup", {14'd0, sram_grant, sram_we, sram_addr}, {14'd0, 1'b1, 1'b0, 17'd645});
        cyc();
        chk("sw_write", {22'd0, sram_grant, sram_we, sram_wdata}, {22'd0, 1'b1, 1'b1, 8'hA5});
        cyc();
        chk("sw_hold", {30'd0, sram_grant, sram_we}, {30'd0, 1'b1, 1'b0});
        cyc();
        chk("sw_idle", {30'd0, sram_grant, sram_we}, 32'd0);
        chk("sw_count", {27'd0, fifo_count}, 32'd0);
        wait_drain(50);

        // Window edge on an odd display line.
        cyc();
        v_count = 12'd47; h_count = 12'd150;
        st = setup_q.size();
        for (int i = 0; i < 6; i++) do_push(10 + i, 20, 8'(8'h40 + i), 1'b1);
        wait_drain(2000);
        chk("we_setup0", {8'd0, setup_q[st]},     {8'd0, 12'd47, 12'd152});
        chk("we_setup1", {8'd0, setup_q[st + 1]}, {8'd0, 12'd47, 12'd155});
        chk("we_next_line", {8'd0, setup_q[st + 2]}, {8'd0, 12'd48, 12'd1});

        // Fill and drain while the window is closed.
        cyc();
        v_count = 12'd47; h_count = 12'd300;
        st  = setup_q.size();
        wst = we_cyc.size();
        for (int i = 0; i < 17; i++) do_push(i, 3 * i, 8'(8'h10 + i), (i < 16) ? 1'b1 : 1'b0);
        chk("fill_count", {27'd0, fifo_count}, 32'd16);
        chk("fill_ready", {31'd0, wr_ready}, 32'd0);
        wait_drain(3000);
        chk("fill_first_setup", {8'd0, setup_q[st]}, {8'd0, 12'd48, 12'd1});
        chk("fill_write_count", 32'(we_cyc.size() - wst), 32'd16);
        for (int k = 1; k < 16; k++)
            chk("fill_spacing", 32'(we_cyc[wst + k] - we_cyc[wst + k - 1]), 32'd3);
        chk("fill_count_end", {27'd0, fifo_count}, 32'd0);

        // Out-of-range writes and the sticky error flag.
        cyc();
        v_count = 12'd10; h_count = 12'd0;
        do_push(320, 0, 8'h11, 1'b1);
        chk("oor_x_err", {31'd0, range_err}, 32'd1);
        chk("oor_x_count", {27'd0, fifo_count}, 32'd0);
        do_push(0, 240, 8'h22, 1'b1);
        chk("oor_y_err", {31'd0, range_err}, 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("err_clr", {31'd0, range_err}, 32'd0);
        err_clr = 1'b1;
        do_push(320, 5, 8'h33, 1'b1);
        err_clr = 1'b0;
        chk("err_set_wins", {31'd0, range_err}, 32'd1);
        repeat (10) cyc();
        chk("oor_no_push", {27'd0, fifo_count}, 32'd0);

        // Corner addresses.
        do_push(319, 239, 8'h3C, 1'b1);
        do_push(0, 0, 8'hC3, 1'b1);
        wait_drain(200);

        // Reset in the middle of a WRITE cycle.
        do_push(7, 3, 8'h5A, 1'b1);
        begin
            int n = 0;
            while (!sram_we && n < 10) begin cyc(); n++; end
            chk("rst_we_seen", {31'd0, sram_we}, 32'd1);
        end
        reset_n = 1'b0;
        void'(expq.pop_back());
        #1;
        chk("mid_rst_we", {31'd0, sram_we}, 32'd0);
        chk("mid_rst_grant", {31'd0, sram_grant}, 32'd0);
        chk("mid_rst_count", {27'd0, fifo_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (20) cyc();
        chk("post_rst_grant", {31'd0, sram_grant}, 32'd0);
        chk("post_rst_count", {27'd0, fifo_count}, 32'd0);
        do_push(100, 100, 8'h77, 1'b1);
        wait_drain(200);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
